// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: scoreboard-based RAW stalls,
// redirect flushes, data-memory freeze and post-halt drain.
module hazard_ctrl #(
    parameter bit          CHECK_WB  = 1'b0,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DRAIN_CYC = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic             id_rd1_used_i,
    input  logic             id_rd2_used_i,
    input  logic [2:0]       id_rs1_i,
    input  logic [2:0]       id_rs2_i,
    input  logic             id_wr_en_i,
    input  logic [2:0]       id_wr_reg_i,
    input  logic             id_halt_i,
    input  logic             ex_redirect_i,
    input  logic             mem_busy_i,
    output logic             pc_en_o,
    output logic             ifid_en_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             pipe_hold_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned DrainW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e            state_q;
    logic [DrainW-1:0] drain_q;
    logic              ex_vld_q, mem_vld_q, wb_vld_q;
    logic [2:0]        ex_reg_q, mem_reg_q, wb_reg_q;
    logic              halted_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic match1, match2, hazard, stall_inc, go_drain;

    always_comb begin
        match1 = (ex_vld_q && ex_reg_q == id_rs1_i) || (mem_vld_q && mem_reg_q == id_rs1_i) ||
                 (CHECK_WB && wb_vld_q && wb_reg_q == id_rs1_i);
        match2 = (ex_vld_q && ex_reg_q == id_rs2_i) || (mem_vld_q && mem_reg_q == id_rs2_i) ||
                 (CHECK_WB && wb_vld_q && wb_reg_q == id_rs2_i);
        hazard = id_valid_i && ((id_rd1_used_i && match1) || (id_rd2_used_i && match2));
        stall_inc = (state_q == StRun) && (mem_busy_i || (!ex_redirect_i && hazard));
        go_drain  = (state_q == StRun) && id_valid_i && id_halt_i && !hazard && !mem_busy_i &&
                    !ex_redirect_i;
    end

    // Priority-ordered output select; reset forces the pipe to bubbles.
    always_comb begin
        pc_en_o      = 1'b1;
        ifid_en_o    = 1'b1;
        ifid_flush_o = 1'b0;
        idex_flush_o = 1'b0;
        pipe_hold_o  = 1'b0;
        if (!rst_ni || state_q == StHalted) begin
            pc_en_o      = 1'b0;
            ifid_en_o    = 1'b0;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else if (mem_busy_i) begin
            pc_en_o     = 1'b0;
            ifid_en_o   = 1'b0;
            pipe_hold_o = 1'b1;
        end else if (state_q == StRun && ex_redirect_i) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else if (state_q == StDrain) begin
            pc_en_o      = 1'b0;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else if (hazard) begin
            pc_en_o      = 1'b0;
            ifid_en_o    = 1'b0;
            idex_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StRun;
            drain_q     <= '0;
            ex_vld_q    <= 1'b0;
            mem_vld_q   <= 1'b0;
            wb_vld_q    <= 1'b0;
            ex_reg_q    <= '0;
            mem_reg_q   <= '0;
            wb_reg_q    <= '0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (!mem_busy_i) begin
                wb_vld_q  <= mem_vld_q;
                wb_reg_q  <= mem_reg_q;
                mem_vld_q <= ex_vld_q;
                mem_reg_q <= ex_reg_q;
                ex_vld_q  <= id_valid_i && id_wr_en_i && !idex_flush_o;
                ex_reg_q  <= id_wr_reg_i;
            end
            if (stall_inc && stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            case (state_q)
                StRun: begin
                    if (go_drain) begin
                        state_q <= StDrain;
                        drain_q <= DrainW'(DRAIN_CYC);
                    end
                end
                StDrain: begin
                    if (!mem_busy_i) begin
                        if (drain_q <= DrainW'(1)) begin
                            state_q  <= StHalted;
                            halted_q <= 1'b1;
                        end else begin
                            drain_q <= drain_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= StHalted;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    assign halted_o    = halted_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core: IF, ID, EX, MEM, WB.
- Tracks in-flight destination registers in a scoreboard. Generates PC/IF-ID enables, ID/EX bubble insertion, and flushes for taken branches/jumps.
- Freezes the pipe on data-memory busy and drains the pipe after a decoded halt.
- Sits beside the decode stage and drives the enable/flush pins of the IF/ID and ID/EX pipeline registers and the PC register.

Parameters:
- CHECK_WB, 0, 1 = also stall on a RAW against the WB slot (register file without write-through bypass); 0 = WB writes visible same cycle.
- CNT_W, 16, width of the stall performance counter.
- DRAIN_CYC, 3, cycles from halt leaving ID until it retires in WB.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction (not a bubble)
- id_rd1_used  in  1  instruction reads instr[10:8]
- id_rd2_used  in  1  instruction reads instr[7:5]
- id_rs1  in  3  read select 1
- id_rs2  in  3  read select 2
- id_wr_en  in  1  instruction writes a register
- id_wr_reg  in  3  destination register
- id_halt  in  1  instruction is HALT
- ex_redirect  in  1  branch/jump in EX resolved taken
- mem_busy  in  1  data memory not ready; whole pipe must hold
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_flush  out  1  ID/EX loads a NOP (bubble)
- pipe_hold  out  1  EX/MEM and MEM/WB hold (= mem_busy in RUN/DRAIN)
- halted  out  1  sticky, halt retired
- stall_cnt  out  CNT_W  cycles lost to hazard or mem_busy stalls, saturating

Behaviour:
- Reset (rst=0, async): state=RUN, scoreboard entries invalid, drain counter=0, halted=0, stall_cnt=0. While rst=0, outputs are forced to pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, pipe_hold=0.
- Scoreboard: three slots {valid, reg} for EX, MEM and WB. They advance on every cycle with mem_busy=0: WB<=MEM, MEM<=EX, EX<=entry.
  - entry = {id_valid & id_wr_en & ~idex_flush, id_wr_reg}.
  - With mem_busy=1, all slots hold.
- hazard = id_valid & ((id_rd1_used & match(id_rs1)) | (id_rd2_used & match(id_rs2))).
  - match(r) = (EX.valid & EX.reg==r) | (MEM.valid & MEM.reg==r) | (CHECK_WB & WB.valid & WB.reg==r).
  - r0 is an ordinary register with no special case.
- Outputs are combinational from state, scoreboard and inputs, evaluated in priority order (first match wins):
  1. state=HALTED: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, pipe_hold=0.
  2. mem_busy: pc_en=0, ifid_en=0, flushes=0, pipe_hold=1. ex_redirect is ignored; upstream holds it stable until busy clears.
  3. ex_redirect (RUN only): pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1. Any concurrent hazard or halt in ID is discarded.
  4. state=DRAIN: pc_en=0, ifid_en=1, ifid_flush=1, idex_flush=1.
  5. hazard: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0.
  6. Otherwise: pc_en=1, ifid_en=1, flushes=0.
- Stall latency, no forwarding, CHECK_WB=0:
  - Producer immediately ahead (EX distance): 2 bubbles.
  - Producer two ahead (MEM distance): 1 bubble.
- FSM:
  - RUN -> DRAIN when id_valid & id_halt & ~hazard & ~mem_busy & ~ex_redirect; drain counter loads DRAIN_CYC.
  - DRAIN: counter decrements on each cycle with mem_busy=0. At 1 -> HALTED.
  - HALTED: terminal until reset; halted=1.
- stall_cnt increments, saturating at all-ones, on each cycle in RUN where mem_busy or hazard selected the outputs. DRAIN and HALTED cycles are not counted.
- Reset mid-DRAIN or in HALTED returns to RUN with an empty scoreboard and all counters cleared.

Test Plan:
- ADD r3 writes, then immediately ADD reads r3 (rs1=3) -> idex_flush=1, pc_en=0 for exactly 2 cycles, then issue; stall_cnt=2.
- Writer of r5, one independent instruction, then reader of r5 via rs2 -> exactly 1 bubble; reader with id_rd2_used=0 -> 0 bubbles.
- Hazard active in ID and ex_redirect=1 the same cycle -> ifid_flush=idex_flush=pc_en=1 in that cycle, no stall; next cycle the scoreboard EX slot is invalid.
- mem_busy=1 for 4 cycles mid-stream -> pc_en=ifid_en=0, pipe_hold=1 for 4 cycles, scoreboard unchanged, stall_cnt+=4, resume with no lost or duplicated instruction.
- HALT decoded with no hazard -> 3 DRAIN cycles (pc_en=0, flushes=1), halted=1 on the 4th cycle and stays set. Repeat with mem_busy=1 for 2 cycles during DRAIN -> halted delayed by 2 cycles.
- Assert rst=0 during DRAIN -> outputs immediately take reset values; after release state=RUN, halted=0, stall_cnt=0, pc_en=1.
